// File: rtl/eth_type_dispatch.sv
// rtl/eth_type_dispatch.sv - steers formatter frames to IPv4/ARP consumers, drains and counts others
module eth_type_dispatch #(
  parameter int DATA_W     = 512,
  parameter int PADBYTES_W = 6,
  parameter int SIZE_W     = 16,
  parameter int TS_W       = 64,
  parameter int ETH_HDR_W  = 112,
  parameter int DROP_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_disp_hdr_val,
  input  logic [ETH_HDR_W-1:0]  src_disp_eth_hdr,
  input  logic [SIZE_W-1:0]     src_disp_data_size,
  input  logic [TS_W-1:0]       src_disp_timestamp,
  output logic                  disp_src_hdr_rdy,
  input  logic                  src_disp_data_val,
  input  logic [DATA_W-1:0]     src_disp_data,
  input  logic                  src_disp_data_last,
  input  logic [PADBYTES_W-1:0] src_disp_data_padbytes,
  output logic                  disp_src_data_rdy,
  output logic                  disp_ip_hdr_val,
  output logic                  disp_arp_hdr_val,
  input  logic                  ip_disp_hdr_rdy,
  input  logic                  arp_disp_hdr_rdy,
  output logic [ETH_HDR_W-1:0]  disp_dst_eth_hdr,
  output logic [SIZE_W-1:0]     disp_dst_data_size,
  output logic [TS_W-1:0]       disp_dst_timestamp,
  output logic                  disp_ip_data_val,
  output logic                  disp_arp_data_val,
  input  logic                  ip_disp_data_rdy,
  input  logic                  arp_disp_data_rdy,
  output logic [DATA_W-1:0]     disp_dst_data,
  output logic                  disp_dst_data_last,
  output logic [PADBYTES_W-1:0] disp_dst_data_padbytes,
  output logic [DROP_CNT_W-1:0] disp_drop_cnt
);

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

  typedef enum logic [1:0] {HDR_WAIT, HDR_OUT, DATA_PASS, DATA_DROP} state_t;
  typedef enum logic [1:0] {DEST_NONE, DEST_IP, DEST_ARP} dest_t;

  state_t                r_state;
  state_t                w_next_state;
  dest_t                 r_dest;
  dest_t                 w_hdr_dest;
  logic [ETH_HDR_W-1:0]  r_eth_hdr;
  logic [SIZE_W-1:0]     r_data_size;
  logic [TS_W-1:0]       r_timestamp;
  logic [DROP_CNT_W-1:0] r_drop_cnt;
  logic                  w_hdr_accept;
  logic                  w_drop_done;

  assign w_hdr_accept = (r_state == HDR_WAIT) && src_disp_hdr_val;

  always_comb begin
    w_hdr_dest = DEST_NONE;
    if (src_disp_eth_hdr[15:0] == ETH_TYPE_IPV4) begin
      w_hdr_dest = DEST_IP;
    end else if (src_disp_eth_hdr[15:0] == ETH_TYPE_ARP) begin
      w_hdr_dest = DEST_ARP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HDR_WAIT;
      r_dest      <= DEST_NONE;
      r_eth_hdr   <= '0;
      r_data_size <= '0;
      r_timestamp <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_hdr_accept) begin
        r_dest      <= w_hdr_dest;
        r_eth_hdr   <= src_disp_eth_hdr;
        r_data_size <= src_disp_data_size;
        r_timestamp <= src_disp_timestamp;
      end
      if (w_drop_done && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_drop_done       = 1'b0;
    disp_src_hdr_rdy  = 1'b0;
    disp_src_data_rdy = 1'b0;
    disp_ip_hdr_val   = 1'b0;
    disp_arp_hdr_val  = 1'b0;
    disp_ip_data_val  = 1'b0;
    disp_arp_data_val = 1'b0;
    case (r_state)
      HDR_WAIT: begin
        // Early payload is held off upstream until the header has been routed.
        disp_src_hdr_rdy = 1'b1;
        if (src_disp_hdr_val) begin
          w_next_state = (w_hdr_dest == DEST_NONE) ? DATA_DROP : HDR_OUT;
        end
      end
      HDR_OUT: begin
        disp_ip_hdr_val  = (r_dest == DEST_IP);
        disp_arp_hdr_val = (r_dest == DEST_ARP);
        if ((r_dest == DEST_IP && ip_disp_hdr_rdy) || (r_dest == DEST_ARP && arp_disp_hdr_rdy)) begin
          w_next_state = DATA_PASS;
        end
      end
      DATA_PASS: begin
        disp_ip_data_val  = (r_dest == DEST_IP) && src_disp_data_val;
        disp_arp_data_val = (r_dest == DEST_ARP) && src_disp_data_val;
        disp_src_data_rdy = (r_dest == DEST_IP) ? ip_disp_data_rdy : arp_disp_data_rdy;
        if (src_disp_data_val && disp_src_data_rdy && src_disp_data_last) begin
          w_next_state = HDR_WAIT;
        end
      end
      DATA_DROP: begin
        disp_src_data_rdy = 1'b1;
        if (src_disp_data_val && src_disp_data_last) begin
          w_drop_done  = 1'b1;
          w_next_state = HDR_WAIT;
        end
      end
      default: w_next_state = HDR_WAIT;
    endcase
  end

  assign disp_dst_eth_hdr       = r_eth_hdr;
  assign disp_dst_data_size     = r_data_size;
  assign disp_dst_timestamp     = r_timestamp;
  assign disp_dst_data          = src_disp_data;
  assign disp_dst_data_last     = src_disp_data_last;
  assign disp_dst_data_padbytes = src_disp_data_padbytes;
  assign disp_drop_cnt          = r_drop_cnt;

endmodule
